// File: rtl/chunked_adder.sv
// Multi-cycle adder: sums two N-bit operands W bits per clock, carrying between chunks in a register.
// Define CHUNKED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module chunked_adder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
`ifdef CHUNKED_ADDER_OVF_EN
    output logic         ovf,
`endif
    output logic         cout
);

    localparam int CHUNKS = N / W;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if (W < 1 || W > N || (N % W) != 0) begin : g_bad_cfg
        $error("chunked_adder: N must be a positive multiple of W");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [N-1:0]     a_r, b_r;
    logic [W-1:0]     ca, cb, s;
    logic [W:0]       chunk_sum;
    logic             c, last;

    assign ca        = a_r[int'(idx)*W +: W];
    assign cb        = b_r[int'(idx)*W +: W];
    assign chunk_sum = {1'b0, ca} + {1'b0, cb} + {{W{1'b0}}, carry};
    assign s         = chunk_sum[W-1:0];
    assign c         = chunk_sum[W];
    assign last      = (idx == IDX_W'(CHUNKS - 1));

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && in_valid) begin
                a_r   <= a;
                b_r   <= b;
                carry <= cin;
                idx   <= '0;
                sum   <= '0;
                cout  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
                ovf   <= 1'b0;
`endif
            end else if (state_q == RUN) begin
                sum[int'(idx)*W +: W] <= s;
                carry                 <= c;
                if (last) begin
                    idx  <= '0;
                    cout <= c;
`ifdef CHUNKED_ADDER_OVF_EN
                    // carry into the top bit recovered from its sum bit: s = a ^ b ^ cin
                    ovf  <= c ^ (s[W-1] ^ ca[W-1] ^ cb[W-1]);
`endif
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: three configurations (16/4, 8/1, 8/8) driven by directed and random
// operations and compared against an arithmetic reference model.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[3];
    logic        ordy[3];
    logic [15:0] av[3];
    logic [15:0] bv[3];
    logic        cv[3];
    logic        iry[3];
    logic        ov[3];
    logic        co[3];
    logic        of[3];
    logic [15:0] sum0;
    logic [7:0]  sum1, sum2;
    logic [15:0] sm[3];

    int checks = 0;
    int errors = 0;
    int nw[3] = '{16, 8, 8};
    int cw[3] = '{4, 8, 1};

    always #5 clk = ~clk;

    assign sm[0] = sum0;
    assign sm[1] = {8'h00, sum1};
    assign sm[2] = {8'h00, sum2};

`ifndef CHUNKED_ADDER_OVF_EN
    assign of[0] = 1'b0;
    assign of[1] = 1'b0;
    assign of[2] = 1'b0;
`endif

    chunked_adder #(.N(16), .W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(iry[0]),
        .a(av[0]), .b(bv[0]), .cin(cv[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(sum0),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(of[0]),
`endif
        .cout(co[0]));

    chunked_adder #(.N(8), .W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(iry[1]),
        .a(av[1][7:0]), .b(bv[1][7:0]), .cin(cv[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(sum1),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(of[1]),
`endif
        .cout(co[1]));

    chunked_adder #(.N(8), .W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(iry[2]),
        .a(av[2][7:0]), .b(bv[2][7:0]), .cin(cv[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(sum2),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(of[2]),
`endif
        .cout(co[2]));

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    // Reference: plain integer addition at n+1 bits; overflow from carries into and out of the MSB.
    task automatic model(input int n, input logic [15:0] x, input logic [15:0] y, input logic c,
                         output logic [15:0] s, output logic co_o, output logic ov_o);
        longint unsigned mask, lowm, full, cm;
        mask = (64'd1 << n) - 1;
        lowm = mask >> 1;
        full = (64'(x) & mask) + (64'(y) & mask) + 64'(c);
        s    = 16'(full & mask);
        co_o = 1'(full >> n);
        cm   = (64'(x) & lowm) + (64'(y) & lowm) + 64'(c);
        ov_o = 1'(cm >> (n - 1)) ^ co_o;
    endtask

    task automatic do_op(input int d, input logic [15:0] a_i, input logic [15:0] b_i, input logic c_i,
                         input int bp, input bit chaos);
        logic [15:0] es;
        logic        eco, eov;
        model(nw[d], a_i, b_i, c_i, es, eco, eov);
        chk("in_ready_idle", d, 32'(iry[d]), 32'd1);
        iv[d] = 1'b1; av[d] = a_i; bv[d] = b_i; cv[d] = c_i; ordy[d] = 1'b0;
        @(negedge clk);
        iv[d] = 1'b0;
        for (int k = 0; k < cw[d]; k++) begin
            chk("valid_early", d, 32'(ov[d]), 32'd0);
            chk("in_ready_busy", d, 32'(iry[d]), 32'd0);
            if (chaos) begin
                iv[d] = 1'($urandom); av[d] = 16'($urandom); bv[d] = 16'($urandom); cv[d] = 1'($urandom);
            end
            @(negedge clk);
        end
        chk("latency_valid", d, 32'(ov[d]), 32'd1);
        chk("sum", d, 32'(sm[d]), 32'(es));
        chk("cout", d, 32'(co[d]), 32'(eco));
`ifdef CHUNKED_ADDER_OVF_EN
        chk("ovf", d, 32'(of[d]), 32'(eov));
`endif
        for (int k = 0; k < bp; k++) begin
            if (chaos) begin
                iv[d] = 1'($urandom); av[d] = 16'($urandom); bv[d] = 16'($urandom);
            end
            @(negedge clk);
            chk("bp_valid", d, 32'(ov[d]), 32'd1);
            chk("bp_sum", d, 32'(sm[d]), 32'(es));
            chk("bp_cout", d, 32'(co[d]), 32'(eco));
            chk("bp_in_ready", d, 32'(iry[d]), 32'd0);
        end
        iv[d] = 1'b0; ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        chk("valid_drop", d, 32'(ov[d]), 32'd0);
        chk("idle_ready", d, 32'(iry[d]), 32'd1);
        chk("sum_retain", d, 32'(sm[d]), 32'(es));
        chk("cout_retain", d, 32'(co[d]), 32'(eco));
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; av[d] = '0; bv[d] = '0; cv[d] = 1'b0;
        end
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("rst_sum", d, 32'(sm[d]), 32'd0);
                chk("rst_cout", d, 32'(co[d]), 32'd0);
                chk("rst_valid", d, 32'(ov[d]), 32'd0);
                chk("rst_in_ready", d, 32'(iry[d]), 32'd0);
            end
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("release_ready", d, 32'(iry[d]), 32'd1);
        @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            do_op(d, 16'h0001, 16'h0001, 1'b0, 0, 1'b0);
            do_op(d, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
            do_op(d, 16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
            do_op(d, 16'h1234, 16'h4321, 1'b0, 5, 1'b1);

            // reset on the second RUN edge, with a competing in_valid at the reset edge
            iv[d] = 1'b1; av[d] = 16'h00FF; bv[d] = 16'h0001; cv[d] = 1'b0;
            @(negedge clk);
            iv[d] = 1'b0;
            @(negedge clk);
            rst = 1'b1; iv[d] = 1'b1; av[d] = 16'h0F0F;
            @(negedge clk);
            rst = 1'b0; iv[d] = 1'b0;
            chk("midrst_valid", d, 32'(ov[d]), 32'd0);
            chk("midrst_sum", d, 32'(sm[d]), 32'd0);
            chk("midrst_cout", d, 32'(co[d]), 32'd0);
            #1;
            chk("midrst_ready", d, 32'(iry[d]), 32'd1);
            @(negedge clk);
            chk("midrst_no_accept", d, 32'(iry[d]), 32'd1);
            do_op(d, 16'h0010, 16'h0020, 1'b0, 0, 1'b0);

`ifdef CHUNKED_ADDER_OVF_EN
            do_op(d, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
            do_op(d, 16'h8000, 16'h8000, 1'b0, 0, 1'b0);
            do_op(d, 16'h0003, 16'h0004, 1'b0, 0, 1'b0);
`endif
            repeat (15) begin
                do_op(d, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Multi-cycle, parametrised successor to the combinational ripple-carry adder.
- Adds two N-bit operands plus carry-in by processing W bits per clock, with the inter-chunk carry held in a register.
- Valid/ready handshakes on input and output let it sit in datapaths where wide combinational carry chains miss timing.
- Trades latency (N/W cycles) for a short critical path of W bits.

Parameters:
- N, 16, total operand width in bits; must be a positive multiple of W.
- W, 4, chunk width added per clock; 1 <= W <= N; W == N gives a single-cycle RUN.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept operands.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  N  registered sum.
- cout  output  1  registered carry out of bit N-1.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Constants:
  - CHUNKS = N/W.
  - Chunk counter idx is max(1, $clog2(CHUNKS)) bits wide.
  - N % W != 0 is an elaboration-time error.
- State machine: IDLE, RUN, DONE.
- Reset (rst high at a clk edge):
  - state=IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0.
  - Operand registers are cleared to 0.
  - Reset has priority over every other event, including mid-RUN and mid-DONE. The in-flight operation is discarded and no result is produced.
- in_ready = (state==IDLE) && !rst. It is combinational from state.
- out_valid = (state==DONE). It is registered via state.
- IDLE:
  - An edge with in_valid && in_ready latches a, b, cin into internal regs.
  - On that edge: carry<=cin, idx<=0, sum<=0, cout<=0, state<=RUN.
  - in_valid is ignored in RUN and DONE; operands are not sampled there.
- RUN, each edge:
  - {c, s} = a_r[idx*W +: W] + b_r[idx*W +: W] + carry, computed at W+1 bits.
  - sum[idx*W +: W] <= s; carry <= c; idx <= idx+1.
  - If idx == CHUNKS-1: cout <= c, idx <= 0, state <= DONE.
- Latency: out_valid rises exactly CHUNKS edges after the accepting edge.
- DONE:
  - sum and cout hold stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - An edge with out_ready=1 returns state to IDLE. sum and cout retain the last result.
  - Operands are not accepted in the DONE cycle. Minimum throughput is one operation per CHUNKS+2 cycles.
- Arithmetic: unsigned modulo 2^N. {cout, sum} == a + b + cin at full N+1-bit width.
- Wrap-around: a carry generated in chunk k propagates to chunk k+1 on the next edge only, via the carry reg. A carry out of the top chunk goes only to cout.
- Simultaneous events:
  - rst with in_valid: the reset wins and nothing is accepted.
  - rst with out_ready in DONE: the reset wins and out_valid falls next cycle.

Optional Feature:
- Macro CHUNKED_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf, 1 bit, registered.
  - On the final RUN edge, ovf <= carry into bit N-1 XOR carry out of bit N-1. This is two's-complement signed overflow.
  - The carry into bit N-1 is derived inside the top-chunk computation.
  - ovf is reset to 0, cleared on accept, and held through DONE alongside sum.
- When undefined: the port does not exist and no related logic is present. All other behaviour is identical.

Test Plan:
1. Reset:
   - Stimulus: rst high for 2 edges, then low.
   - Required response: sum=0, cout=0, out_valid=0 throughout; in_ready=0 while rst=1 and 1 on the first cycle after release.
2. Basic and latency, N=16 W=4:
   - Stimulus: a=0x0001, b=0x0001, cin=0, accepted at edge t; out_ready=1.
   - Required response: out_valid=1 first at edge t+4; sum=0x0002, cout=0; out_valid low after one cycle.
3. Full carry ripple:
   - Stimulus: a=0xFFFF, b=0x0001, cin=0.
   - Required response: sum=0x0000, cout=1.
   - Stimulus: a=0xFFFF, b=0xFFFF, cin=1.
   - Required response: sum=0xFFFF, cout=1.
4. Backpressure and ignored input:
   - Stimulus: a=0x1234, b=0x4321, cin=0; hold out_ready=0 for 5 cycles after out_valid; toggle in_valid with new operands in RUN/DONE.
   - Required response: sum=0x5555, cout=0, stable for all 5 cycles; in_ready=0; new operands are never latched; IDLE the edge after out_ready=1.
5. Reset mid-RUN:
   - Stimulus: accept a=0x00FF, b=0x0001; assert rst on the 2nd RUN edge; then run a=0x0010, b=0x0020.
   - Required response: state IDLE, out_valid=0, sum=0 after the reset edge; next result sum=0x0030, cout=0.
6. Overflow (CHUNKED_ADDER_OVF_EN defined):
   - Stimulus: a=0x7FFF, b=0x0001.
   - Required response: ovf=1, cout=0, sum=0x8000.
   - Stimulus: a=0x8000, b=0x8000.
   - Required response: ovf=1, cout=1, sum=0x0000.
   - Stimulus: a=0x0003, b=0x0004.
   - Required response: ovf=0.
   - Also: repeat scenarios 2-5 with N=8 W=8 and N=8 W=1, checking latency of CHUNKS edges.
